// File: rtl/ipm_multi_ch.sv
// Bridge from the 8-bit asynchronous MCU bus to N_CH AIP slave channels.
// Build option IPM_CH_AUTOINC_EN: advance the channel select after every completed word.
module ipm_multi_ch #(
    parameter int unsigned MCU_DW      = 8,
    parameter int unsigned AIP_DW      = 32,
    parameter int unsigned CONF_W      = 5,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             mcu_addr,
    input  logic                   mcu_rd,
    input  logic                   mcu_wr,
    input  logic [MCU_DW-1:0]      mcu_data_in,
    output logic [MCU_DW-1:0]      mcu_data_out,
    output logic                   mcu_data_oe,
    output logic                   mcu_int,
    output logic [AIP_DW-1:0]      aip_data_out,
    input  logic [N_CH*AIP_DW-1:0] aip_data_in,
    output logic [CONF_W-1:0]      aip_conf,
    output logic [N_CH-1:0]        aip_read,
    output logic [N_CH-1:0]        aip_write,
    output logic [N_CH-1:0]        aip_start,
    input  logic [N_CH-1:0]        aip_int
);

    localparam int unsigned BPW   = AIP_DW / MCU_DW;
    localparam int unsigned CNT_W = ($clog2(BPW) > 3) ? $clog2(BPW) : 3;
    localparam int unsigned SEL_W = 3;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_CAP, RD_OUT} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q;
    logic                rd_dly_q, wr_dly_q;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CONF_W-1:0]   conf_q, conf_d;
    logic [N_CH-1:0]     mask_q, mask_d, pend_q, pend_d, pend_clr;
    logic [N_CH-1:0]     int_q, int_dly_q;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [AIP_DW-1:0]   wsh_q, wsh_d, word_q, word_d, aout_q, aout_d, ch_word;
    logic [3:0]          rd_addr_q, rd_addr_d;
    logic                hold_v_q, hold_v_d, hold_wr_q, hold_wr_d;
    logic [3:0]          hold_addr_q, hold_addr_d;
    logic [MCU_DW-1:0]   hold_data_q, hold_data_d;
    logic [MCU_DW-1:0]   dout_q, dout_d;
    logic                mcu_int_q;
    logic [N_CH-1:0]     read_q, read_d, write_q, write_d, start_q, start_d;
    logic [N_CH-1:0]     sel_oh;
    logic                rd_s, wr_s, rd_rise, rd_fall, wr_rise;
    logic                op_v, op_wr, wr_left, rd_left;
    logic [3:0]          op_addr;
    logic [MCU_DW-1:0]   op_data;

    assign rd_s    = rd_sync_q[SYNC_STAGES-1];
    assign wr_s    = wr_sync_q[SYNC_STAGES-1];
    assign rd_rise = rd_s & ~rd_dly_q;
    assign rd_fall = ~rd_s & rd_dly_q;
    assign wr_rise = wr_s & ~wr_dly_q;
    assign sel_oh  = N_CH'(1) << sel_q;

`ifdef IPM_CH_AUTOINC_EN
    logic [SEL_W-1:0] sel_next;
    assign sel_next = (sel_q == SEL_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
`endif

    // Read word of the currently selected channel
    always_comb begin
        ch_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_q == SEL_W'(i)) ch_word = aip_data_in[i*AIP_DW +: AIP_DW];
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        conf_d      = conf_q;
        mask_d      = mask_q;
        ovf_d       = ovf_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        wsh_d       = wsh_q;
        word_d      = word_q;
        aout_d      = aout_q;
        dout_d      = dout_q;
        rd_addr_d   = rd_rise ? mcu_addr : rd_addr_q;
        hold_v_d    = hold_v_q;
        hold_wr_d   = hold_wr_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        read_d      = '0;
        write_d     = '0;
        start_d     = '0;
        pend_clr    = '0;
        op_v        = 1'b0;
        op_wr       = 1'b0;
        op_addr     = '0;
        op_data     = '0;
        wr_left     = wr_rise;
        rd_left     = rd_rise;

        // Held event first, then write before read
        if (state_q == IDLE) begin
            if (hold_v_q) begin
                op_v = 1'b1; op_wr = hold_wr_q; op_addr = hold_addr_q; op_data = hold_data_q;
                hold_v_d = 1'b0;
            end else if (wr_rise) begin
                op_v = 1'b1; op_wr = 1'b1; op_addr = mcu_addr; op_data = mcu_data_in;
                wr_left = 1'b0;
            end else if (rd_rise) begin
                op_v = 1'b1; op_addr = mcu_addr;
                rd_left = 1'b0;
            end
        end

        if (op_v && op_wr) begin
            case (op_addr)
                4'd0: begin
                    wsh_d = (wsh_q >> MCU_DW) | (AIP_DW'(op_data) << (AIP_DW - MCU_DW));
                    if (wcnt_q == LAST_BYTE) begin
                        write_d = sel_oh;
                        aout_d  = wsh_d;
                        wcnt_d  = '0;
`ifdef IPM_CH_AUTOINC_EN
                        sel_d  = sel_next;
                        rcnt_d = '0;
`endif
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                4'd1: conf_d = op_data[CONF_W-1:0];
                4'd2: begin
                    if (op_data < MCU_DW'(N_CH)) begin
                        sel_d = SEL_W'(op_data);
                        if (SEL_W'(op_data) != sel_q) begin
                            wcnt_d = '0;
                            rcnt_d = '0;
                        end
                    end
                end
                4'd3: begin
                    if (op_data[0]) start_d = sel_oh;
                    if (op_data[1]) begin
                        wcnt_d = '0;
                        rcnt_d = '0;
                    end
                end
                4'd4: pend_clr = op_data[N_CH-1:0];
                4'd5: mask_d   = op_data[N_CH-1:0];
                4'd6: ovf_d    = 1'b0;
                default: ;
            endcase
        end else if (op_v) begin
            case (op_addr)
                4'd0: begin
                    if (rcnt_q == '0) begin
                        state_d = RD_REQ;
                        read_d  = sel_oh;
                    end else begin
                        dout_d = MCU_DW'(word_q >> (32'(rcnt_q) * MCU_DW));
                    end
                end
                4'd1:    dout_d = MCU_DW'(conf_q);
                4'd2:    dout_d = MCU_DW'(sel_q);
                4'd4:    dout_d = MCU_DW'(pend_q);
                4'd5:    dout_d = MCU_DW'(mask_q);
                4'd6:    dout_d = MCU_DW'({ovf_q, wcnt_q[2:0], rcnt_q[2:0], 1'b0});
                default: dout_d = '0;
            endcase
        end

        case (state_q)
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                word_d  = ch_word;
                dout_d  = ch_word[MCU_DW-1:0];
                state_d = RD_OUT;
            end
            RD_OUT: state_d = IDLE;
            default: ;
        endcase

        // Byte pointer of DATA reads advances when the strobe is released
        if (rd_fall && rd_addr_q == 4'd0) begin
            if (rcnt_q == LAST_BYTE) begin
                rcnt_d = '0;
`ifdef IPM_CH_AUTOINC_EN
                sel_d  = sel_next;
                wcnt_d = '0;
`endif
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        // Events not serviced this cycle go to the one-deep hold or are lost
        if (wr_left) begin
            if (!hold_v_d) begin
                hold_v_d = 1'b1; hold_wr_d = 1'b1; hold_addr_d = mcu_addr; hold_data_d = mcu_data_in;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (rd_left) begin
            if (!hold_v_d) begin
                hold_v_d = 1'b1; hold_wr_d = 1'b0; hold_addr_d = mcu_addr; hold_data_d = mcu_data_in;
            end else begin
                ovf_d = 1'b1;
            end
        end

        pend_d = (pend_q & ~pend_clr) | (int_q & ~int_dly_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_sync_q   <= '0;
            wr_sync_q   <= '0;
            rd_dly_q    <= 1'b0;
            wr_dly_q    <= 1'b0;
            sel_q       <= '0;
            conf_q      <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            int_q       <= '0;
            int_dly_q   <= '0;
            ovf_q       <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wsh_q       <= '0;
            word_q      <= '0;
            aout_q      <= '0;
            rd_addr_q   <= '0;
            hold_v_q    <= 1'b0;
            hold_wr_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            dout_q      <= '0;
            mcu_int_q   <= 1'b0;
            read_q      <= '0;
            write_q     <= '0;
            start_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], mcu_rd};
            wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], mcu_wr};
            rd_dly_q    <= rd_s;
            wr_dly_q    <= wr_s;
            sel_q       <= sel_d;
            conf_q      <= conf_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            int_q       <= aip_int;
            int_dly_q   <= int_q;
            ovf_q       <= ovf_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wsh_q       <= wsh_d;
            word_q      <= word_d;
            aout_q      <= aout_d;
            rd_addr_q   <= rd_addr_d;
            hold_v_q    <= hold_v_d;
            hold_wr_q   <= hold_wr_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            dout_q      <= dout_d;
            mcu_int_q   <= |(pend_q & mask_q);
            read_q      <= read_d;
            write_q     <= write_d;
            start_q     <= start_d;
        end
    end

    assign mcu_data_out = dout_q;
    assign mcu_data_oe  = rd_s;
    assign mcu_int      = mcu_int_q;
    assign aip_data_out = aout_q;
    assign aip_conf     = conf_q;
    assign aip_read     = read_q;
    assign aip_write    = write_q;
    assign aip_start    = start_q;

endmodule

// File: tb/tb_ipm_multi_ch.sv
// Directed bench for ipm_multi_ch: register access, word assembly, word read, interrupts, overrun.
module tb_ipm_multi_ch;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   mcu_addr;
    logic         mcu_rd, mcu_wr;
    logic [7:0]   mcu_data_in, mcu_data_out;
    logic         mcu_data_oe, mcu_int;
    logic [31:0]  aip_data_out;
    logic [127:0] aip_data_in;
    logic [4:0]   aip_conf;
    logic [3:0]   aip_read, aip_write, aip_start, aip_int;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0, rd_pulses = 0, st_pulses = 0;
    logic [3:0]  wr_last = '0, rd_last = '0, st_last = '0;
    logic [31:0] wdata_last = '0;

    ipm_multi_ch dut (
        .clk(clk), .rst(rst), .mcu_addr(mcu_addr), .mcu_rd(mcu_rd), .mcu_wr(mcu_wr),
        .mcu_data_in(mcu_data_in), .mcu_data_out(mcu_data_out), .mcu_data_oe(mcu_data_oe),
        .mcu_int(mcu_int), .aip_data_out(aip_data_out), .aip_data_in(aip_data_in),
        .aip_conf(aip_conf), .aip_read(aip_read), .aip_write(aip_write),
        .aip_start(aip_start), .aip_int(aip_int)
    );

    always #5 clk = ~clk;

    // Pulse recorder
    always @(negedge clk) begin
        if (!rst) begin
            if (aip_write != 0) begin wr_pulses++; wr_last = aip_write; wdata_last = aip_data_out; end
            if (aip_read  != 0) begin rd_pulses++; rd_last = aip_read; end
            if (aip_start != 0) begin st_pulses++; st_last = aip_start; end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mcu_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        mcu_addr = a; mcu_data_in = d; mcu_wr = 1'b1;
        repeat (3) @(negedge clk);
        mcu_wr = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic mcu_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        mcu_addr = a; mcu_rd = 1'b1;
        repeat (7) @(negedge clk);
        d = mcu_data_out;
        mcu_rd = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int base;
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'hD4; exp_rd[1] = 8'hC3; exp_rd[2] = 8'hB2; exp_rd[3] = 8'hA1;

        rst = 1'b1; mcu_addr = '0; mcu_rd = 1'b0; mcu_wr = 1'b0; mcu_data_in = '0; aip_int = '0;
        aip_data_in = {32'h44444444, 32'h33333333, 32'hA1B2C3D4, 32'h0F0E0D0C};
        repeat (3) @(negedge clk);
        check("rst_dout", 64'(mcu_data_out), 64'h0);
        check("rst_pulses", 64'({aip_read, aip_write, aip_start}), 64'h0);
        check("rst_misc", 64'({mcu_data_oe, mcu_int, aip_conf, aip_data_out}), 64'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // T1: reset in the middle of a read request
        mcu_addr = 4'd0; mcu_rd = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_rd_req", 64'(aip_read), 64'h1);
        rst = 1'b1;
        #1;
        check("t1_rd_abort", 64'(aip_read), 64'h0);
        check("t1_outs", 64'({mcu_data_oe, mcu_int, mcu_data_out, aip_conf, aip_write, aip_start}), 64'h0);
        check("t1_aout", 64'(aip_data_out), 64'h0);
        mcu_rd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        mcu_read(4'd5, b);
        check("t1_mask", 64'(b), 64'h0);
        base = st_pulses;
        mcu_write(4'd3, 8'h01);
        check("t1_start_cnt", 64'(st_pulses - base), 64'd1);
        check("t1_sel0", 64'(st_last), 64'h1);

        // CONF keeps only CONF_W bits
        mcu_write(4'd1, 8'hFF);
        check("conf_pins", 64'(aip_conf), 64'h1F);
        mcu_read(4'd1, b);
        check("conf_rd", 64'(b), 64'h1F);

        // T2: word write on channel 2
        mcu_write(4'd2, 8'd2);
        base = wr_pulses;
        mcu_write(4'd0, 8'h44);
        mcu_write(4'd0, 8'h33);
        mcu_write(4'd0, 8'h22);
        check("t2_no_early_wr", 64'(wr_pulses - base), 64'd0);
        mcu_write(4'd0, 8'h11);
        check("t2_wr_cnt", 64'(wr_pulses - base), 64'd1);
        check("t2_wr_ch", 64'(wr_last), 64'h4);
        check("t2_wr_word", 64'(wdata_last), 64'h11223344);

        // T3: word read from channel 1
        mcu_write(4'd2, 8'd1);
        base = rd_pulses;
        for (int i = 0; i < 4; i++) begin
            mcu_read(4'd0, b);
            check($sformatf("t3_byte%0d", i), 64'(b), 64'(exp_rd[i]));
        end
        check("t3_rd_cnt", 64'(rd_pulses - base), 64'd1);
        check("t3_rd_ch", 64'(rd_last), 64'h2);

        // T4: masked interrupt aggregation and W1C
        mcu_write(4'd5, 8'h05);
        @(negedge clk);
        aip_int = 4'b0011;
        repeat (4) @(negedge clk);
        mcu_read(4'd4, b);
        check("t4_pend", 64'(b), 64'h3);
        check("t4_int_on", 64'(mcu_int), 64'h1);
        mcu_write(4'd4, 8'h01);
        mcu_read(4'd4, b);
        check("t4_pend_w1c", 64'(b), 64'h2);
        check("t4_int_off", 64'(mcu_int), 64'h0);
        aip_int = '0;

        // T5: out-of-range CHSEL is ignored
        mcu_write(4'd2, 8'd7);
        base = st_pulses;
        mcu_write(4'd3, 8'h01);
        check("t5_start_cnt", 64'(st_pulses - base), 64'd1);
        check("t5_sel_kept", 64'(st_last), 64'h2);
        mcu_read(4'd6, b);
        check("t5_status0", 64'(b), 64'h00);

        // T5: two writes during a busy read: one held, one dropped
        @(negedge clk);
        mcu_addr = 4'd0; mcu_data_in = 8'h5A; mcu_rd = 1'b1;
        @(negedge clk); mcu_wr = 1'b1;
        @(negedge clk); mcu_wr = 1'b0;
        @(negedge clk); mcu_wr = 1'b1;
        @(negedge clk); mcu_wr = 1'b0;
        repeat (6) @(negedge clk);
        mcu_rd = 1'b0;
        repeat (5) @(negedge clk);
        mcu_read(4'd6, b);
        check("t5_status_ovf", 64'(b), 64'h92);
        mcu_write(4'd6, 8'h00);
        mcu_read(4'd6, b);
        check("t5_ovf_clr", 64'(b), 64'h12);
        mcu_write(4'd3, 8'h02);
        mcu_read(4'd6, b);
        check("t5_cnt_clr", 64'(b), 64'h00);

        // T6: word write on the last channel, then observe the selected channel
        mcu_write(4'd2, 8'd3);
        base = wr_pulses;
        mcu_write(4'd0, 8'h01);
        mcu_write(4'd0, 8'h02);
        mcu_write(4'd0, 8'h03);
        mcu_write(4'd0, 8'h04);
        check("t6_wr_cnt", 64'(wr_pulses - base), 64'd1);
        check("t6_wr_ch", 64'(wr_last), 64'h8);
        check("t6_wr_word", 64'(wdata_last), 64'h04030201);
        mcu_write(4'd3, 8'h01);
`ifdef IPM_CH_AUTOINC_EN
        check("t6_sel_after", 64'(st_last), 64'h1);
`else
        check("t6_sel_after", 64'(st_last), 64'h8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
